key_step_gen: RTL and testbench
===============================

// Module: key_step_gen
// PURPOSE
//  Debounces one raw active-low pushbutton and produces a clean step clock for the
//  4-bit hex counter / 7-seg stage downstream. The counter advances on the falling edge
//  of its clock, so step_clk idles high and drops low for one fixed-width pulse per
//  debounced press. An optional auto-repeat mode emits further pulses while the key is held.
// PARAMETERS
//  SYNC_STAGES      2           synchronizer depth on key_n (>=2)
//  DEBOUNCE_CYCLES  1000000     stable cycles required to accept a press or release (20 ms @ 50 MHz)
//  PULSE_LEN        4           step_clk low time in clk cycles (>=1)
//  REPEAT_EN        0           1 = auto-repeat while held
//  REPEAT_DELAY     25000000    cycles from press pulse to first repeat pulse
//  REPEAT_RATE      5000000     cycles between later repeat pulses (must be > 2*PULSE_LEN)
//  CNT_W            25          timer width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  reset      in   1  reset, asynchronous, active-low
//  key_n      in   1  raw pushbutton, 0 = pressed, asynchronous to clk
//  step_clk   out  1  to counter clock input; idle 1, low PULSE_LEN cycles per step
//  key_level  out  1  debounced key state, 1 = pressed
//  busy       out  1  1 while pulse low or in post-pulse guard
// BEHAVIOUR
//  Reset (async): step_clk=1, key_level=0, busy=0, sync flops=1 (released), FSM=IDLE, timers=0.
//  FSM states (registered, next-state comb):
//   IDLE         : synced key released. synced low -> PRESS_WAIT, timer cleared.
//   PRESS_WAIT   : timer++ while synced low; synced high -> IDLE (bounce, no output).
//                  timer reaches DEBOUNCE_CYCLES -> HELD, key_level<=1, trigger pulse.
//   HELD         : REPEAT_EN: repeat timer triggers pulse at REPEAT_DELAY, then every
//                  REPEAT_RATE. synced high -> RELEASE_WAIT, timer cleared.
//   RELEASE_WAIT : timer++ while synced high; synced low -> HELD (no new pulse; repeat
//                  timer continues from its held value). timer reaches DEBOUNCE_CYCLES ->
//                  IDLE, key_level<=0.
//  Latency: counting the first edge sampling key_n low as edge 1, key_level rises and
//   step_clk falls on edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (key_n stable throughout).
//  Pulse gen: trigger -> step_clk low exactly PULSE_LEN cycles, then high; busy stays 1 for
//   PULSE_LEN further guard cycles (min high time). Triggers while busy=1 are dropped.
//  Release never produces a pulse. Exactly one step per accepted press when REPEAT_EN=0.
//  Timers saturate; never wrap. Any bounce resets the debounce timer to 0.
//  Reset mid-operation: outputs return to reset values immediately, a pulse in progress is
//   truncated (counter sees one falling edge). Key held through reset release is debounced
//   again from IDLE and yields one pulse.
//  step_clk driven directly from a flop (glitch-free; it is used as a clock).
// STRUCTURE
//  key_defs.vh: FSM state encodings (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), 2-bit state width.
//  Sub-module sync_ff #(STAGES, RESET_VAL): n-stage synchronizer, async active-low reset.
//  Top holds FSM, debounce timer, repeat timer, pulse/guard counter.
// TESTING (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, PULSE_LEN=2, REPEAT_DELAY=40,
//  REPEAT_RATE=10, CNT_W=8)
//  1 clean press held 30 cycles, release -> key_level rises edge 11, step_clk low edges 11-12
//    only, key_level falls 11 edges after release, exactly one pulse total.
//  2 press bouncing every 3 cycles for 15 cycles then stable low -> exactly one pulse, at
//    edge 11 counted from last bounce-to-low.
//  3 key_n low for 5 cycles then high -> no pulse, key_level stays 0, FSM back to IDLE.
//  4 REPEAT_EN=1, stay in HELD 75 cycles -> pulses at HELD-entry +0,+40,+50,+60,+70 = 5 pulses.
//  5 reset asserted while step_clk low, key still held -> step_clk=1, key_level=0 same
//    cycle; after reset release exactly one pulse at edge 11.
//  6 release with 4-cycle bounce back to low, then real release -> no extra pulse,
//    key_level stays 1 until final debounced release.

Source files
------------

// File: rtl/key_step_gen_pkg.sv
// Shared definitions for the pushbutton step-clock generator.
// This file holds the debounce FSM encodings, the pulse-generator phases and the
// idle level of the raw key input.
package key_step_gen_pkg;

    // Debounce FSM state encodings. The 2-bit width matches older code that uses them.
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE         = 2'd0;
    localparam logic [STATE_W-1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [STATE_W-1:0] ST_HELD         = 2'd2;
    localparam logic [STATE_W-1:0] ST_RELEASE_WAIT = 2'd3;

    // Level of key_n when the button is not pressed.
    localparam logic KEY_RELEASED = 1'b1;

    // Phases of the step pulse generator.
    // LOW drives step_clk low. GUARD enforces the minimum high time that follows.
    typedef enum logic [1:0] {
        PG_IDLE  = 2'd0,
        PG_LOW   = 2'd1,
        PG_GUARD = 2'd2
    } pulse_phase_t;

endpackage

// File: rtl/key_step_gen_sync_ff.sv
// N-stage synchronizer that brings the raw key input into the clk domain.
// The reset value is the key's idle level, so no false press can appear when reset is released.
module sync_ff
    import key_step_gen_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = KEY_RELEASED
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is always assigned with <=, so every flop in the chain
        // samples the value it had before this clock edge. With = the chain would collapse to one stage.
        if (!reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/key_step_gen.sv
// Debounces an active-low pushbutton and produces a glitch-free step clock for the
// falling-edge hex counter that follows. step_clk idles high. It goes low for PULSE_LEN
// cycles on each accepted press, and also on each auto-repeat when REPEAT_EN is set.
module key_step_gen
    import key_step_gen_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_LEN       = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic step_clk,
    output logic key_level,
    output logic busy
);

    // A timer is compared with "target - 1" because the cycle that reaches the target
    // is the same cycle that acts on it.
    localparam logic [CNT_W-1:0] DEB_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic             REP_ON         = (REPEAT_EN != 0);

    localparam int               PCNT_W     = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_LEN - 1);

    // Increment that stops at all-ones, so a timer never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic key_sync;
    logic key_low;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (KEY_RELEASED)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_n),
        .q     (key_sync)
    );

    assign key_low = ~key_sync;

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   deb_cnt;
    logic [CNT_W-1:0]   deb_cnt_nxt;
    logic               level_nxt;
    logic               press_trig;

    // Next-state logic. Any disagreement between the synced key and the pending state restarts the debounce.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that does not
        // assign a signal would otherwise infer a latch.
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        level_nxt   = key_level;
        press_trig  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_low) begin
                    state_nxt   = ST_PRESS_WAIT;
                    deb_cnt_nxt = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!key_low) begin
                    state_nxt   = ST_IDLE;
                    deb_cnt_nxt = '0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_nxt   = ST_HELD;
                    deb_cnt_nxt = '0;
                    level_nxt   = 1'b1;
                    press_trig  = 1'b1;
                end else begin
                    deb_cnt_nxt = sat_inc(deb_cnt);
                end
            end
            ST_HELD: begin
                if (!key_low) begin
                    state_nxt   = ST_RELEASE_WAIT;
                    deb_cnt_nxt = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (key_low) begin
                    // Bounce during release: return quietly. The repeat timer keeps its value.
                    state_nxt   = ST_HELD;
                    deb_cnt_nxt = '0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_nxt   = ST_IDLE;
                    deb_cnt_nxt = '0;
                    level_nxt   = 1'b0;
                end else begin
                    deb_cnt_nxt = sat_inc(deb_cnt);
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                deb_cnt_nxt = '0;
                level_nxt   = 1'b0;
            end
        endcase
    end

    // Register the FSM state, the debounce timer and the debounced level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            deb_cnt   <= '0;
            key_level <= 1'b0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_cnt_nxt;
            key_level <= level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat timer
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] rep_cnt;
    logic             rep_first_done;
    logic             rep_trig;

    // The first repeat fires REPEAT_DELAY cycles after the press pulse. Later repeats fire every REPEAT_RATE cycles.
    always_comb begin
        rep_trig = 1'b0;
        if (REP_ON && (state == ST_HELD)) begin
            if (rep_first_done) begin
                rep_trig = (rep_cnt >= REP_RATE_LAST);
            end else begin
                rep_trig = (rep_cnt >= REP_DELAY_LAST);
            end
        end
    end

    // The timer restarts on each press pulse and advances only while the key is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt        <= '0;
            rep_first_done <= 1'b0;
        end else if (press_trig) begin
            rep_cnt        <= '0;
            rep_first_done <= 1'b0;
        end else if (state == ST_HELD) begin
            if (rep_trig) begin
                rep_cnt        <= '0;
                rep_first_done <= 1'b1;
            end else begin
                rep_cnt <= sat_inc(rep_cnt);
            end
        end
    end

    // ------------------------------------------------------------------
    // Step pulse generator
    // ------------------------------------------------------------------
    pulse_phase_t      phase;
    logic [PCNT_W-1:0] pcnt;
    logic              trig;

    assign trig = press_trig | rep_trig;

    // step_clk comes straight from this flop, so the downstream counter's clock cannot glitch.
    // A trigger that arrives outside PG_IDLE is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase    <= PG_IDLE;
            pcnt     <= '0;
            step_clk <= 1'b1;
        end else begin
            case (phase)
                PG_IDLE: begin
                    if (trig) begin
                        phase    <= PG_LOW;
                        pcnt     <= '0;
                        step_clk <= 1'b0;
                    end
                end
                PG_LOW: begin
                    if (pcnt == PULSE_LAST) begin
                        phase    <= PG_GUARD;
                        pcnt     <= '0;
                        step_clk <= 1'b1;
                    end else begin
                        pcnt <= pcnt + PCNT_W'(1);
                    end
                end
                PG_GUARD: begin
                    if (pcnt == PULSE_LAST) begin
                        phase <= PG_IDLE;
                        pcnt  <= '0;
                    end else begin
                        pcnt <= pcnt + PCNT_W'(1);
                    end
                end
                default: begin
                    phase    <= PG_IDLE;
                    pcnt     <= '0;
                    step_clk <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (phase != PG_IDLE);

endmodule

// File: tb/tb_key_step_gen.sv
// Directed bench for key_step_gen.
// Two instances share clk, reset and key_n: dut0 has auto-repeat off and dut1 has it on.
// In each test, key_n is replayed from a per-edge queue. Expected outputs come from a
// table of {edge, instance, step_clk, key_level, busy}. Edge 1 is the first posedge
// that samples the first queued key value. Outputs are sampled 1 time unit after each posedge.
module tb_key_step_gen;

    logic clk = 1'b0;
    logic reset;
    logic key_n;
    logic step0, lvl0, busy0;
    logic step1, lvl1, busy1;

    int nvec   = 0;
    int nfail  = 0;
    int falls0 = 0;
    int falls1 = 0;

    typedef struct {
        int   at_edge;
        logic rep;
        logic exp_step;
        logic exp_lvl;
        logic exp_busy;
    } chk_t;

    chk_t tbl[$];
    logic key_q[$];

    always #5 clk = ~clk;

    // Count the falling edges of step_clk that the downstream counter would see.
    always @(negedge step0) falls0 = falls0 + 1;
    always @(negedge step1) falls1 = falls1 + 1;

    key_step_gen #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .PULSE_LEN(2), .REPEAT_EN(0),
        .REPEAT_DELAY(40), .REPEAT_RATE(10), .CNT_W(8)
    ) dut0 (
        .clk(clk), .reset(reset), .key_n(key_n),
        .step_clk(step0), .key_level(lvl0), .busy(busy0)
    );

    key_step_gen #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .PULSE_LEN(2), .REPEAT_EN(1),
        .REPEAT_DELAY(40), .REPEAT_RATE(10), .CNT_W(8)
    ) dut1 (
        .clk(clk), .reset(reset), .key_n(key_n),
        .step_clk(step1), .key_level(lvl1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_key(input logic v, input int n);
        for (int i = 0; i < n; i++) key_q.push_back(v);
    endtask

    task automatic expect_at(input int e, input logic rep, input logic s, input logic l, input logic b);
        tbl.push_back('{at_edge: e, rep: rep, exp_step: s, exp_lvl: l, exp_busy: b});
    endtask

    task automatic clear_test();
        tbl.delete();
        key_q.delete();
    endtask

    // Drive one key value before each edge and check any table rows due at that edge.
    task automatic run_seq(input string name);
        int idx = 0;
        for (int e = 1; e <= key_q.size(); e++) begin
            key_n = key_q[e-1];
            tick();
            while (idx < tbl.size() && tbl[idx].at_edge == e) begin
                if (tbl[idx].rep) begin
                    check($sformatf("%s e%0d rep step_clk", name, e), 32'(step1), 32'(tbl[idx].exp_step));
                    check($sformatf("%s e%0d rep key_level", name, e), 32'(lvl1), 32'(tbl[idx].exp_lvl));
                    check($sformatf("%s e%0d rep busy", name, e), 32'(busy1), 32'(tbl[idx].exp_busy));
                end else begin
                    check($sformatf("%s e%0d step_clk", name, e), 32'(step0), 32'(tbl[idx].exp_step));
                    check($sformatf("%s e%0d key_level", name, e), 32'(lvl0), 32'(tbl[idx].exp_lvl));
                    check($sformatf("%s e%0d busy", name, e), 32'(busy0), 32'(tbl[idx].exp_busy));
                end
                idx++;
            end
        end
    endtask

    initial begin
        int base0;
        int base1;

        // Reset state
        reset = 1'b0;
        key_n = 1'b1;
        repeat (3) tick();
        check("reset step_clk", 32'(step0), 32'd1);
        check("reset key_level", 32'(lvl0), 32'd0);
        check("reset busy", 32'(busy0), 32'd0);
        reset = 1'b1;
        repeat (5) tick();

        // Test 1: clean press, held 30 edges, then released
        clear_test();
        add_key(1'b0, 30); add_key(1'b1, 15);
        expect_at(10, 0, 1, 0, 0);
        expect_at(11, 0, 0, 1, 1);
        expect_at(12, 0, 0, 1, 1);
        expect_at(13, 0, 1, 1, 1);
        expect_at(14, 0, 1, 1, 1);
        expect_at(15, 0, 1, 1, 0);
        expect_at(30, 0, 1, 1, 0);
        expect_at(40, 0, 1, 1, 0);
        expect_at(41, 0, 1, 0, 0);
        base0 = falls0;
        run_seq("t1");
        check("t1 pulse count", 32'(falls0 - base0), 32'd1);

        // Test 2: press bounces every 3 cycles for 15 cycles. The last low run starts at edge 13.
        clear_test();
        add_key(1'b0, 3); add_key(1'b1, 3); add_key(1'b0, 3); add_key(1'b1, 3);
        add_key(1'b0, 18); add_key(1'b1, 15);
        expect_at(9, 0, 1, 0, 0);
        expect_at(22, 0, 1, 0, 0);
        expect_at(23, 0, 0, 1, 1);
        expect_at(24, 0, 0, 1, 1);
        expect_at(25, 0, 1, 1, 1);
        expect_at(41, 0, 1, 0, 0);
        base0 = falls0;
        run_seq("t2");
        check("t2 pulse count", 32'(falls0 - base0), 32'd1);

        // Test 3: a short 5-cycle press is rejected
        clear_test();
        add_key(1'b0, 5); add_key(1'b1, 20);
        expect_at(5, 0, 1, 0, 0);
        expect_at(8, 0, 1, 0, 0);
        expect_at(11, 0, 1, 0, 0);
        expect_at(15, 0, 1, 0, 0);
        expect_at(25, 0, 1, 0, 0);
        base0 = falls0;
        run_seq("t3");
        check("t3 pulse count", 32'(falls0 - base0), 32'd0);

        // Test 4: auto-repeat. HELD is entered at edge 11 and left at edge 86.
        clear_test();
        add_key(1'b0, 83); add_key(1'b1, 20);
        expect_at(11, 1, 0, 1, 1);
        expect_at(50, 1, 1, 1, 0);
        expect_at(51, 0, 1, 1, 0);
        expect_at(51, 1, 0, 1, 1);
        expect_at(53, 1, 1, 1, 1);
        expect_at(61, 1, 0, 1, 1);
        expect_at(71, 1, 0, 1, 1);
        expect_at(81, 1, 0, 1, 1);
        expect_at(82, 1, 0, 1, 1);
        expect_at(83, 1, 1, 1, 1);
        expect_at(91, 1, 1, 1, 0);
        expect_at(94, 1, 1, 0, 0);
        base0 = falls0;
        base1 = falls1;
        run_seq("t4");
        check("t4 repeat pulse count", 32'(falls1 - base1), 32'd5);
        check("t4 no-repeat pulse count", 32'(falls0 - base0), 32'd1);

        // Test 5: reset is asserted while step_clk is low and the key stays held
        clear_test();
        add_key(1'b0, 11);
        expect_at(10, 0, 1, 0, 0);
        expect_at(11, 0, 0, 1, 1);
        base0 = falls0;
        run_seq("t5a");
        reset = 1'b0;
        #1;
        check("t5 reset step_clk", 32'(step0), 32'd1);
        check("t5 reset key_level", 32'(lvl0), 32'd0);
        check("t5 reset busy", 32'(busy0), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        clear_test();
        add_key(1'b0, 25); add_key(1'b1, 15);
        expect_at(10, 0, 1, 0, 0);
        expect_at(11, 0, 0, 1, 1);
        expect_at(12, 0, 0, 1, 1);
        expect_at(13, 0, 1, 1, 1);
        expect_at(36, 0, 1, 0, 0);
        run_seq("t5b");
        check("t5 pulse count", 32'(falls0 - base0), 32'd2);

        // Test 6: the release bounces back low for 4 cycles before the real release
        clear_test();
        add_key(1'b0, 20); add_key(1'b1, 3); add_key(1'b0, 4); add_key(1'b1, 17);
        expect_at(11, 0, 0, 1, 1);
        expect_at(24, 0, 1, 1, 0);
        expect_at(26, 0, 1, 1, 0);
        expect_at(30, 0, 1, 1, 0);
        expect_at(37, 0, 1, 1, 0);
        expect_at(38, 0, 1, 0, 0);
        base0 = falls0;
        run_seq("t6");
        check("t6 pulse count", 32'(falls0 - base0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
